// File: rtl/divider_scale_ctrl.sv
// divider_scale_ctrl
//   Arbitrates scale-change requests from two requesters (A, B) and reprograms a clock
//   divider. Each reprogram holds the divider in reset for HOLD_CYCLES, then waits
//   SETTLE_CYCLES after release before acknowledging the granted requester.
//   Ties are resolved round-robin; A wins the first tie after reset.
//
// Optional feature (compile-time macro):
//   DIVCTRL_SKIP_SAME_EN - a granted scale equal to cur_scale skips HOLD/SETTLE and is
//                          acknowledged on the next cycle with div_nrst kept high.
//
// Ports:
//   clk_in            - sole clock, rising edge
//   nrst              - asynchronous active-low reset
//   req_a / req_b     - level requests for a scale change
//   scale_a / scale_b - requested scale, valid while the matching req is high
//   ack_a / ack_b     - one-cycle completion pulse to the granted requester
//   div_nrst          - divider active-low reset
//   div_scale         - divider scale, changes only at grant
//   cur_scale         - last scale fully applied (acknowledged)
//   busy              - high in every state except idle
module divider_scale_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] scale_a,
  input  logic [WIDTH-1:0] scale_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             div_nrst,
  output logic [WIDTH-1:0] div_scale,
  output logic [WIDTH-1:0] cur_scale,
  output logic             busy
);

  localparam int unsigned MaxCycles  = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CntW       = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StHold,
    StSettle,
    StAck
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  div_scale_q, div_scale_d;
  logic [WIDTH-1:0]  cur_scale_q, cur_scale_d;
  logic              grant_b_q, grant_b_d;  // requester owning the current grant (1 = B)
  logic              last_b_q, last_b_d;    // last granted requester (1 = B)

  logic              pick_b;
  logic [WIDTH-1:0]  pick_scale;

  // B wins if it is the only requester, or on a tie when A was granted last.
  assign pick_b     = req_b & (~req_a | ~last_b_q);
  assign pick_scale = pick_b ? scale_b : scale_a;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    div_scale_d = div_scale_q;
    cur_scale_d = cur_scale_q;
    grant_b_d   = grant_b_q;
    last_b_d    = last_b_q;

    unique case (state_q)
      StInit: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (req_a || req_b) begin
          grant_b_d   = pick_b;
          last_b_d    = pick_b;
          div_scale_d = pick_scale;
`ifdef DIVCTRL_SKIP_SAME_EN
          if (pick_scale == cur_scale_q) begin
            state_d     = StAck;
            cur_scale_d = pick_scale;
          end else begin
            state_d = StHold;
          end
`else
          state_d = StHold;
`endif
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d     = StAck;
          cnt_d       = '0;
          cur_scale_d = div_scale_q;
        end
      end
      StAck: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      div_scale_q <= '0;
      cur_scale_q <= '0;
      grant_b_q   <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_scale_q <= div_scale_d;
      cur_scale_q <= cur_scale_d;
      grant_b_q   <= grant_b_d;
      last_b_q    <= last_b_d;
    end
  end

  // Outputs decode straight from the state register so reset forces them immediately.
  assign div_nrst  = (state_q == StIdle) || (state_q == StSettle) || (state_q == StAck);
  assign busy      = (state_q != StIdle);
  assign ack_a     = (state_q == StAck) && !grant_b_q;
  assign ack_b     = (state_q == StAck) && grant_b_q;
  assign div_scale = div_scale_q;
  assign cur_scale = cur_scale_q;

endmodule

// File: tb/tb_divider_scale_ctrl.sv
module tb_divider_scale_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int S = 16;

  logic         clk_in;
  logic         nrst;
  logic         req_a, req_b;
  logic [W-1:0] scale_a, scale_b;
  logic         ack_a, ack_b;
  logic         div_nrst;
  logic [W-1:0] div_scale, cur_scale;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: last applied scale and round-robin owner (1 = B granted last).
  logic [W-1:0] cur_m;
  bit           ptr_b_m;

  divider_scale_ctrl #(
    .WIDTH        (W),
    .HOLD_CYCLES  (H),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk_in   (clk_in),
    .nrst     (nrst),
    .req_a    (req_a),
    .req_b    (req_b),
    .scale_a  (scale_a),
    .scale_b  (scale_b),
    .ack_a    (ack_a),
    .ack_b    (ack_b),
    .div_nrst (div_nrst),
    .div_scale(div_scale),
    .cur_scale(cur_scale),
    .busy     (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serves one grant starting at the current IDLE cycle k (sampled at negedge).
  // mode 0: no scale changes, 1: random scale changes while busy, 2: granted scale -> 9.
  task automatic serve(input int mode, output int who);
    int           g;
    int           lat;
    bit           skip;
    logic         en;
    logic [W-1:0] s;
    who = -1;
    n_cmp++;
    if (busy !== 1'b0 || div_nrst !== 1'b1) begin
      n_err++;
      $display("FAIL serve_idle: busy=%b div_nrst=%b required 0/1", busy, div_nrst);
    end
    if (req_a && req_b) g = ptr_b_m ? 0 : 1;
    else                g = req_a ? 0 : 1;
    s       = (g == 0) ? scale_a : scale_b;
    ptr_b_m = (g == 1);
    skip    = 1'b0;
`ifdef DIVCTRL_SKIP_SAME_EN
    skip = (s == cur_m);
`endif
    lat = skip ? 1 : 1 + H + S;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk_in);
      en = skip ? 1'b1 : (j > H);
      n_cmp++;
      if (div_scale !== s) begin
        n_err++;
        $display("FAIL div_scale j=%0d: got %0h required %0h", j, div_scale, s);
      end
      n_cmp++;
      if (div_nrst !== en) begin
        n_err++;
        $display("FAIL div_nrst j=%0d: got %b required %b", j, div_nrst, en);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy j=%0d: got %b required 1", j, busy);
      end
      n_cmp++;
      if (ack_a !== (j == lat && g == 0) || ack_b !== (j == lat && g == 1)) begin
        n_err++;
        $display("FAIL ack j=%0d: got a=%b b=%b required a=%b b=%b", j, ack_a, ack_b,
                 (j == lat && g == 0), (j == lat && g == 1));
      end
      if (j == lat) begin
        if (ack_a === 1'b1)      who = 0;
        else if (ack_b === 1'b1) who = 1;
        n_cmp++;
        if (cur_scale !== s) begin
          n_err++;
          $display("FAIL cur_scale_ack: got %0h required %0h", cur_scale, s);
        end
        if (g == 0) req_a = 1'b0;
        else        req_b = 1'b0;
      end else begin
        n_cmp++;
        if (cur_scale !== cur_m) begin
          n_err++;
          $display("FAIL cur_scale_hold j=%0d: got %0h required %0h", j, cur_scale, cur_m);
        end
        if (mode == 1) begin
          scale_a = W'($urandom_range(0, 255));
          scale_b = W'($urandom_range(0, 255));
        end else if (mode == 2 && j == 2) begin
          if (g == 0) scale_a = 8'd9;
          else        scale_b = 8'd9;
        end
      end
    end
    cur_m = s;
    @(negedge clk_in);
    n_cmp++;
    if (busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      n_err++;
      $display("FAIL post_ack: busy=%b ack_a=%b ack_b=%b required 0/0/0", busy, ack_a, ack_b);
    end
  endtask

  task automatic test_reset();
    int n;
    nrst    = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    scale_a = '0;
    scale_b = '0;
    #1;
    n_cmp++;
    if (div_nrst !== 1'b0 || busy !== 1'b1 || ack_a !== 1'b0 || ack_b !== 1'b0 ||
        div_scale !== '0 || cur_scale !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: div_nrst=%b busy=%b ack=%b%b div_scale=%0h cur_scale=%0h",
               div_nrst, busy, ack_a, ack_b, div_scale, cur_scale);
    end
    repeat (3) @(negedge clk_in);
    nrst    = 1'b1;
    cur_m   = '0;
    ptr_b_m = 1'b1;
    n = 0;
    while (div_nrst === 1'b0 && n < 20) begin
      n_cmp++;
      if (busy !== 1'b1 || div_scale !== '0 || cur_scale !== '0) begin
        n_err++;
        $display("FAIL init_outputs n=%0d: busy=%b div_scale=%0h cur_scale=%0h",
                 n, busy, div_scale, cur_scale);
      end
      n++;
      @(negedge clk_in);
    end
    n_cmp++;
    if (n != H) begin
      n_err++;
      $display("FAIL init_length: got %0d cycles required %0d", n, H);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL init_busy_fall: got %b required 0", busy);
    end
  endtask

  task automatic test_scale_change();
    int who;
    req_a   = 1'b1;
    scale_a = 8'd3;
    serve(2, who);
    n_cmp++;
    if (cur_scale !== 8'd3 || div_scale !== 8'd3) begin
      n_err++;
      $display("FAIL scale_change: cur=%0h div=%0h required 3/3", cur_scale, div_scale);
    end
  endtask

  task automatic test_same_scale();
    int who;
    req_a   = 1'b1;
    scale_a = 8'd3;
    serve(0, who);
    n_cmp++;
    if (who != 0) begin
      n_err++;
      $display("FAIL same_scale_who: got %0d required 0", who);
    end
  endtask

  task automatic test_zero_scale();
    int who;
    req_b   = 1'b1;
    scale_b = 8'd0;
    serve(0, who);
    n_cmp++;
    if (cur_scale !== 8'd0) begin
      n_err++;
      $display("FAIL zero_scale: got %0h required 0", cur_scale);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    req_a   = 1'b1;
    scale_a = 8'h2c;
    repeat (H + 5) @(negedge clk_in);
    n_cmp++;
    if (busy !== 1'b1 || div_nrst !== 1'b1) begin
      n_err++;
      $display("FAIL settle_entry: busy=%b div_nrst=%b required 1/1", busy, div_nrst);
    end
    nrst = 1'b0;
    #1;
    n_cmp++;
    if (div_nrst !== 1'b0 || cur_scale !== '0 || div_scale !== '0 || busy !== 1'b1 ||
        ack_a !== 1'b0 || ack_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: div_nrst=%b cur=%0h div=%0h busy=%b ack=%b%b",
               div_nrst, cur_scale, div_scale, busy, ack_a, ack_b);
    end
    req_a = 1'b0;
    repeat (2) @(negedge clk_in);
    nrst    = 1'b1;
    cur_m   = '0;
    ptr_b_m = 1'b1;
    acks    = 0;
    repeat (30) begin
      @(negedge clk_in);
      if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_ack: acks=%0d busy=%b required 0/0", acks, busy);
    end
  endtask

  task automatic test_tie();
    int who1, who2;
    req_a   = 1'b1;
    req_b   = 1'b1;
    scale_a = 8'd5;
    scale_b = 8'd7;
    serve(0, who1);
    serve(0, who2);
    n_cmp++;
    if (who1 != 0 || who2 != 1) begin
      n_err++;
      $display("FAIL tie_order: got %0d,%0d required 0,1", who1, who2);
    end
    n_cmp++;
    if (cur_scale !== 8'd7) begin
      n_err++;
      $display("FAIL tie_cur_scale: got %0h required 7", cur_scale);
    end
  endtask

  task automatic test_random();
    int who;
    int r;
    int gap;
    for (int it = 0; it < 40; it++) begin
      if (!req_a && !req_b) begin
        gap = $urandom_range(0, 3);
        for (int k = 0; k < gap; k++) begin
          n_cmp++;
          if (busy !== 1'b0 || div_nrst !== 1'b1 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
            n_err++;
            $display("FAIL idle_gap: busy=%b div_nrst=%b ack=%b%b", busy, div_nrst, ack_a, ack_b);
          end
          @(negedge clk_in);
        end
        r       = $urandom_range(1, 3);
        req_a   = r[0];
        req_b   = r[1];
        scale_a = ($urandom_range(0, 3) == 0) ? cur_m : W'($urandom_range(0, 255));
        scale_b = ($urandom_range(0, 3) == 0) ? cur_m : W'($urandom_range(0, 255));
      end
      serve(1, who);
    end
  endtask

  initial begin
    test_reset();
    test_scale_change();
    test_same_scale();
    test_zero_scale();
    test_reset_mid();
    test_tie();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
